cyclic_scan_driver: RTL and testbench

CYCLIC_SCAN_DRIVER -- requirements
Module: cyclic_scan_driver

---
 rtl/cyclic_scan_driver.sv | 194 +++++++++++++++++++
 tb/tb_cyclic_scan_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cyclic_scan_driver.sv
// cyclic_scan_driver: walks a single active-low lit channel across the masked set,
// in ring or bounce order, holding each channel for i_dwell+1 cycles.
`default_nettype none

module cyclic_scan_driver #(
   parameter int N_CH    = 4,
   parameter int DWELL_W = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_en,
   input  logic [DWELL_W-1:0]       i_dwell,
   input  logic                     i_mode,
   input  logic                     i_dir,
   input  logic [N_CH-1:0]          i_mask,
   output logic [N_CH-1:0]          o_sensor_LED,
   output logic [$clog2(N_CH)-1:0]  o_idx,
   output logic                     o_step,
   output logic                     o_frame
);

   localparam int IW = $clog2(N_CH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]         state_q;
   logic [0:0]         state_d;
   logic [IW-1:0]      idx_q;
   logic [DWELL_W-1:0] cnt_q;
   logic               bdir_q;
   logic               sdir_q;
   logic               mode_q;
   logic               step_q;
   logic               frame_q;

   logic               scan_ok;
   logic               expire;
   logic               enter_bounce;
   logic               dir_b;
   logic               sdir_n;

   logic               up_ok;
   logic               dn_ok;
   logic [IW-1:0]      up_idx;
   logic [IW-1:0]      dn_idx;
   logic [IW-1:0]      lo_idx;
   logic [IW-1:0]      hi_idx;

   logic [IW-1:0]      nxt_idx;
   logic               nxt_bdir;
   logic               nxt_frame;

   assign scan_ok      = i_en && (|i_mask);
   assign expire       = (cnt_q >= i_dwell);
   assign enter_bounce = i_mode && !mode_q;
   assign dir_b        = enter_bounce ? i_dir : bdir_q;
   assign sdir_n       = enter_bounce ? i_dir : sdir_q;

   // Nearest included neighbours of the lit channel plus the two endpoints of the set.
   always_comb begin
      up_ok  = 1'b0;
      dn_ok  = 1'b0;
      up_idx = '0;
      dn_idx = '0;
      lo_idx = '0;
      hi_idx = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (i_mask[k]) begin
            lo_idx = IW'(k);
            if (k > int'(idx_q)) begin
               up_ok  = 1'b1;
               up_idx = IW'(k);
            end
         end
      end
      for (int k = 0; k < N_CH; k++) begin
         if (i_mask[k]) begin
            hi_idx = IW'(k);
            if (k < int'(idx_q)) begin
               dn_ok  = 1'b1;
               dn_idx = IW'(k);
            end
         end
      end
   end

   always_comb begin
      nxt_idx   = idx_q;
      nxt_bdir  = bdir_q;
      nxt_frame = 1'b0;
      if (!i_mode) begin
         if (!i_dir) begin
            nxt_idx   = up_ok ? up_idx : lo_idx;
            nxt_frame = !up_ok;
         end else begin
            nxt_idx   = dn_ok ? dn_idx : hi_idx;
            nxt_frame = !dn_ok;
         end
      end else begin
         nxt_bdir = dir_b;
         if (!dir_b) begin
            if (up_ok) begin
               nxt_idx = up_idx;
            end else if (dn_ok) begin
               nxt_idx  = dn_idx;
               nxt_bdir = 1'b1;
            end
         end else begin
            if (dn_ok) begin
               nxt_idx = dn_idx;
            end else if (up_ok) begin
               nxt_idx  = up_idx;
               nxt_bdir = 1'b0;
            end
         end
         // A lone included channel stays put and counts as its own start endpoint.
         nxt_frame = sdir_n ? (nxt_idx == hi_idx) : (nxt_idx == lo_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (scan_ok)  state_d = ST_RUN;
         ST_RUN:  if (!scan_ok) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         cnt_q   <= '0;
         bdir_q  <= 1'b0;
         sdir_q  <= 1'b0;
         mode_q  <= 1'b0;
         step_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         step_q  <= 1'b0;
         frame_q <= 1'b0;
         if (state_q == ST_IDLE) begin
            cnt_q <= '0;
            if (scan_ok) begin
               idx_q  <= i_dir ? hi_idx : lo_idx;
               bdir_q <= i_dir;
               sdir_q <= i_dir;
               mode_q <= i_mode;
               step_q <= 1'b1;
            end else begin
               idx_q <= '0;
            end
         end else if (!scan_ok) begin
            cnt_q <= '0;
            idx_q <= '0;
         end else if (expire) begin
            cnt_q   <= '0;
            idx_q   <= nxt_idx;
            mode_q  <= i_mode;
            step_q  <= 1'b1;
            frame_q <= nxt_frame;
            if (i_mode) begin
               bdir_q <= nxt_bdir;
               sdir_q <= sdir_n;
            end
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      o_sensor_LED = '1;
      o_idx        = '0;
      if (state_q == ST_RUN) begin
         o_sensor_LED = ~(N_CH'(1) << idx_q);
         o_idx        = idx_q;
      end
      o_step  = step_q;
      o_frame = frame_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_cyclic_scan_driver.sv
// tb_cyclic_scan_driver: directed scan scenarios plus randomized traffic against a list-based model.
`default_nettype none

module tb_cyclic_scan_driver;

   localparam int N  = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          mode;
   logic          dir;
   logic [DW-1:0] dwell;
   logic [N-1:0]  mask;
   logic [N-1:0]  led;
   logic [1:0]    idx;
   logic          step;
   logic          frame;

   int nvec = 0;
   int nerr = 0;

   // Reference model state
   bit   m_run;
   int   m_idx;
   int   m_cnt;
   bit   m_bdir;
   bit   m_sdir;
   bit   m_pmode;
   int   incl[$];
   logic [N-1:0] e_led;
   int   e_idx;
   bit   e_step;
   bit   e_frame;

   cyclic_scan_driver #(.N_CH(N), .DWELL_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_en         (en),
      .i_dwell      (dwell),
      .i_mode       (mode),
      .i_dir        (dir),
      .i_mask       (mask),
      .o_sensor_LED (led),
      .o_idx        (idx),
      .o_step       (step),
      .o_frame      (frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Nearest included channel from cur in direction d (0 = up), or -1.
   function automatic int neighbour(int cur, bit d);
      int r;
      r = -1;
      for (int i = 0; i < incl.size(); i++) begin
         if (!d && r < 0 && incl[i] > cur) r = incl[i];
         if (d && incl[i] < cur) r = incl[i];
      end
      return r;
   endfunction

   task automatic model_step();
      int nx;
      incl.delete();
      for (int k = 0; k < N; k++) if (mask[k]) incl.push_back(k);
      e_step  = 0;
      e_frame = 0;
      if (rst) begin
         m_run = 0; m_cnt = 0; m_bdir = 0; m_sdir = 0; m_pmode = 0;
      end else if (!m_run) begin
         if (en && incl.size() > 0) begin
            m_run = 1;
            m_idx = dir ? incl[incl.size()-1] : incl[0];
            m_cnt = 0; m_bdir = dir; m_sdir = dir; m_pmode = mode;
            e_step = 1;
         end
      end else if (!en || incl.size() == 0) begin
         m_run = 0; m_cnt = 0;
      end else if (m_cnt >= int'(dwell)) begin
         m_cnt  = 0;
         e_step = 1;
         if (!mode) begin
            m_pmode = 0;
            nx = neighbour(m_idx, dir);
            if (nx < 0) begin
               nx = dir ? incl[incl.size()-1] : incl[0];
               e_frame = 1;
            end
         end else begin
            if (!m_pmode) begin m_bdir = dir; m_sdir = dir; end
            m_pmode = 1;
            nx = neighbour(m_idx, m_bdir);
            if (nx < 0) begin
               nx = neighbour(m_idx, !m_bdir);
               if (nx >= 0) m_bdir = !m_bdir;
               else nx = m_idx;
            end
            e_frame = (nx == (m_sdir ? incl[incl.size()-1] : incl[0]));
         end
         m_idx = nx;
      end else begin
         m_cnt++;
      end
      e_led = m_run ? ~(N'(1) << m_idx) : '1;
      e_idx = m_run ? m_idx : 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("led",   32'(led),   32'(e_led));
      chk("idx",   32'(idx),   32'(e_idx));
      chk("step",  32'(step),  32'(e_step));
      chk("frame", 32'(frame), 32'(e_frame));
   endtask

   logic [N-1:0] s26 [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
   logic [N-1:0] s27 [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
   int           s28 [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

   initial begin
      rst = 1; en = 0; mode = 0; dir = 0; dwell = '0; mask = '0;
      tick();
      tick();
      chk("rst_led", 32'(led), 32'hF);
      chk("rst_idx", 32'(idx), 0);
      rst = 0;

      // Ring ascending, dwell 0
      mask = 4'b1111; en = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("ring_up_led", 32'(led), 32'(s26[i]));
         chk("ring_up_frame", 32'(frame), 32'(i == 4));
      end
      en = 0; tick();

      // Ring descending, dwell 2
      en = 1; dir = 1; dwell = 2;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("ring_dn_led", 32'(led), 32'(s27[i/3]));
         chk("ring_dn_step", 32'(step), 32'(i % 3 == 0));
      end
      en = 0; tick();

      // Bounce, dwell 0
      en = 1; dir = 0; mode = 1; dwell = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("bounce_idx", 32'(idx), 32'(s28[i]));
         chk("bounce_frame", 32'(frame), 32'(i == 6));
      end
      en = 0; tick();

      // Sparse mask
      en = 1; mode = 0; mask = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("sparse_idx", 32'(idx), (i % 2 == 0) ? 1 : 3);
         chk("sparse_off", 32'({led[2], led[0]}), 32'h3);
      end

      // Reset mid-dwell at idx 2, then restart
      en = 0; tick();
      en = 1; mask = 4'b1111; dwell = 3;
      for (int i = 0; i < 10; i++) tick();
      chk("pre_rst_idx", 32'(idx), 2);
      rst = 1; tick();
      chk("mid_rst_led", 32'(led), 32'hF);
      chk("mid_rst_idx", 32'(idx), 0);
      chk("mid_rst_pulse", 32'({step, frame}), 0);
      rst = 0; tick();
      chk("restart_idx", 32'(idx), 0);
      for (int i = 0; i < 9; i++) tick();
      chk("pre_dis_idx", 32'(idx), 2);
      en = 0; tick();
      chk("dis_led", 32'(led), 32'hF);
      chk("dis_pulse", 32'({step, frame}), 0);
      en = 1; tick();
      chk("reen_idx", 32'(idx), 0);

      // Single channel
      en = 0; tick();
      en = 1; mask = 4'b0100; dwell = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("single_led", 32'(led), 32'hB);
         if (i > 0) begin
            chk("single_step", 32'(step), 32'(i % 2 == 0));
            chk("single_frame", 32'(frame), 32'(i % 2 == 0));
         end
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 7) == 0)  mask  = N'($urandom);
         if ($urandom_range(0, 9) == 0)  dwell = DW'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) mode  = ~mode;
         if ($urandom_range(0, 9) == 0)  dir   = ~dir;
         en = ($urandom_range(0, 29) != 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
